ble_cmd_ctrl: RTL and testbench

Frame-level controller that sits directly behind rx_uart in the BLE control path. It consumes the byte strobe and byte from rx_uart and sequences reception of command frames: start byte, opcode, length, payload and checksum. It buffers the payload, validates the frame, then presents the command to the downstream command executor through a valid/ready handshake. It also flags checksum, length, inter-byte timeout and overrun errors.

---
 rtl/ble_cmd_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_ble_cmd_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// ble_cmd_ctrl
// Frame-level receive controller for the BLE control path. It sits behind
// rx_uart and assembles command frames of the form
//   SOF | OP | LEN | PAYLOAD[LEN] | CHK      (CHK = XOR of OP, LEN, PAYLOAD)
// A frame that checks out is held and offered downstream through a
// valid/ready handshake. The payload can be read by index while it is held.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   rx_valid     one-cycle byte strobe from rx_uart
//   rx_data      received byte, qualified by rx_valid
//   cmd_valid    a complete, checked frame is held
//   cmd_ready    downstream accepts the held frame
//   cmd_op       opcode of the held frame
//   cmd_len      payload length of the held frame
//   rd_addr      payload read index
//   rd_data      payload[rd_addr], 8'h00 when rd_addr >= cmd_len
//   err_chk      one-cycle pulse: checksum mismatch
//   err_len      one-cycle pulse: LEN larger than MAX_LEN
//   err_timeout  one-cycle pulse: inter-byte gap exceeded inside a frame
//   err_overrun  one-cycle pulse: byte arrived while a frame was held
// ---------------------------------------------------------------------------
module ble_cmd_ctrl #(
  parameter int          MAX_LEN        = 16,
  parameter int          TIMEOUT_CYCLES = 2000,
  parameter logic [7:0]  SOF_BYTE       = 8'hAA,
  localparam int         LW             = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    cmd_op,
  output logic [LW-1:0] cmd_len,
  input  logic [LW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_timeout,
  output logic          err_overrun
);

  // Buffer index width; the buffer is rounded up to a power of two so that
  // an index slice never needs a bounds check of its own.
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_OP  = 3'd1,
    GET_LEN = 3'd2,
    GET_PAY = 3'd3,
    GET_CHK = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [7:0]      chk_q, chk_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      op_q, op_d;
  logic [LW-1:0]   len_q, len_d;
  logic            wr_en;
  logic            in_frame;
  logic            tmo_exp;
  logic            e_chk, e_len, e_tmo, e_ovr;

  logic [7:0]      pay_mem [0:DEPTH-1];

  // Timer is only live while a frame is being collected.
  assign in_frame = (state_q == GET_OP) || (state_q == GET_LEN) ||
                    (state_q == GET_PAY) || (state_q == GET_CHK);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign tmo_exp  = in_frame && !rx_valid && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    op_d    = op_q;
    len_d   = len_q;
    wr_en   = 1'b0;
    e_chk   = 1'b0;
    e_len   = 1'b0;
    e_tmo   = 1'b0;
    e_ovr   = 1'b0;

    case (state_q)
      IDLE: begin
        // Anything other than SOF is line noise and is dropped quietly.
        if (rx_valid && (rx_data == SOF_BYTE)) begin
          chk_d   = 8'h00;
          state_d = GET_OP;
        end
      end

      GET_OP: begin
        if (rx_valid) begin
          op_d    = rx_data;
          chk_d   = rx_data;
          state_d = GET_LEN;
        end else if (tmo_exp) begin
          e_tmo   = 1'b1;
          state_d = IDLE;
        end
      end

      GET_LEN: begin
        if (rx_valid) begin
          if (rx_data > MAX_LEN8) begin
            e_len   = 1'b1;
            state_d = IDLE;
          end else begin
            len_d = rx_data[LW-1:0];
            chk_d = chk_q ^ rx_data;
            if (rx_data == 8'h00) begin
              state_d = GET_CHK;
            end else begin
              cnt_d   = '0;
              state_d = GET_PAY;
            end
          end
        end else if (tmo_exp) begin
          e_tmo   = 1'b1;
          state_d = IDLE;
        end
      end

      GET_PAY: begin
        if (rx_valid) begin
          wr_en = 1'b1;
          chk_d = chk_q ^ rx_data;
          cnt_d = cnt_q + LW'(1);
          if (cnt_q == (len_q - LW'(1))) begin
            state_d = GET_CHK;
          end
        end else if (tmo_exp) begin
          e_tmo   = 1'b1;
          state_d = IDLE;
        end
      end

      GET_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d = HOLD;
          end else begin
            e_chk   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_exp) begin
          e_tmo   = 1'b1;
          state_d = IDLE;
        end
      end

      HOLD: begin
        // Bytes in HOLD are never parsed, even on the handshake cycle.
        if (rx_valid) begin
          e_ovr = 1'b1;
        end
        if (cmd_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Timer restarts on every byte and on every state change, and rests at
    // zero outside the collecting states.
    if (in_frame && !rx_valid && (state_d == state_q)) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = '0;
    end
  end

  // ---- control / header registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      chk_q       <= 8'h00;
      tmo_q       <= '0;
      op_q        <= 8'h00;
      len_q       <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      op_q        <= op_d;
      len_q       <= len_d;
      err_chk     <= e_chk;
      err_len     <= e_len;
      err_timeout <= e_tmo;
      err_overrun <= e_ovr;
    end
  end

  // ---- payload buffer (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pay_mem[cnt_q[AW-1:0]] <= rx_data;
    end
  end

  assign cmd_valid = (state_q == HOLD);
  assign cmd_op    = op_q;
  assign cmd_len   = len_q;

  // rd_addr < cmd_len <= MAX_LEN, so the low AW bits address the entry.
  assign rd_data = (rd_addr < len_q) ? pay_mem[rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_ble_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ble_cmd_ctrl
// Directed bench for ble_cmd_ctrl. Frames expected to be accepted are pushed
// to a scoreboard queue when their bytes are driven and popped when the DUT
// presents them. Error pulses are also tallied by a monitor and compared
// against the expected totals at the end.
// ---------------------------------------------------------------------------
module tb_ble_cmd_ctrl;

  localparam int LW = 5;

  logic          clk;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic [LW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_chk;
  logic          err_len;
  logic          err_timeout;
  logic          err_overrun;

  ble_cmd_ctrl #(
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (2000),
    .SOF_BYTE       (8'hAA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       op;
    logic [7:0]       len;
    logic [1:0][7:0]  pay;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  int n_chk = 0;
  int n_len = 0;
  int n_tmo = 0;
  int n_ovr = 0;
  int n_multi = 0;

  always @(posedge clk) begin
    if (err_chk)     n_chk++;
    if (err_len)     n_len++;
    if (err_timeout) n_tmo++;
    if (err_overrun) n_ovr++;
    if ((32'(err_chk) + 32'(err_len) + 32'(err_timeout) + 32'(err_overrun)) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits gap falling edges, strobes one byte, returns on the falling edge
  // right after the strobe was captured.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [7:0] len,
                          input logic [7:0] p0, input logic [7:0] p1);
    exp_t e;
    e.op     = op;
    e.len    = len;
    e.pay[0] = p0;
    e.pay[1] = p1;
    sb.push_back(e);
  endtask

  task automatic check_cmd(input string tag, input bit hs);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    check({tag, "_op"},    32'(cmd_op),    32'(e.op));
    check({tag, "_len"},   32'(cmd_len),   32'(e.len));
    for (int i = 0; i < int'(e.len); i++) begin
      rd_addr = LW'(i);
      #1;
      check({tag, "_rd"}, 32'(rd_data), 32'(e.pay[i]));
    end
    rd_addr = e.len[LW-1:0];
    #1;
    check({tag, "_rd_past_len"}, 32'(rd_data), 32'h00);
    rd_addr = 5'd31;
    #1;
    check({tag, "_rd_max"}, 32'(rd_data), 32'h00);
    rd_addr = '0;
    if (hs) begin
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check({tag, "_released"}, 32'(cmd_valid), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b0;
    rd_addr   = '0;

    // Reset state
    #12;
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_op",    32'(cmd_op),    32'd0);
    check("rst_len",   32'(cmd_len),   32'd0);
    check("rst_errs",  32'({err_chk, err_len, err_timeout, err_overrun}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Nominal frame, 100 cycles between strobes
    push_exp(8'h01, 8'd2, 8'h11, 8'h22);
    send_byte(8'hAA, 100);
    send_byte(8'h01, 100);
    send_byte(8'h02, 100);
    send_byte(8'h11, 100);
    send_byte(8'h22, 100);
    repeat (99) @(negedge clk);
    check("nom_valid_before_chk", 32'(cmd_valid), 32'd0);
    send_byte(8'h30, 0);
    check_cmd("nom", 1'b1);

    // Zero-length frame
    push_exp(8'h05, 8'd0, 8'h00, 8'h00);
    send_byte(8'hAA, 3);
    send_byte(8'h05, 3);
    send_byte(8'h00, 3);
    send_byte(8'h05, 3);
    check_cmd("zero", 1'b1);

    // Bad checksum, then a good frame
    send_byte(8'hAA, 3);
    send_byte(8'h01, 3);
    send_byte(8'h02, 3);
    send_byte(8'h11, 3);
    send_byte(8'h22, 3);
    send_byte(8'h31, 3);
    check("badchk_pulse", 32'(err_chk), 32'd1);
    check("badchk_valid", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    check("badchk_pulse_end", 32'(err_chk), 32'd0);
    check("badchk_valid_later", 32'(cmd_valid), 32'd0);
    push_exp(8'h07, 8'd1, 8'h5A, 8'h00);
    send_byte(8'hAA, 3);
    send_byte(8'h07, 3);
    send_byte(8'h01, 3);
    send_byte(8'h5A, 3);
    send_byte(8'h5C, 3);
    check_cmd("after_bad", 1'b1);

    // Leading noise, then a good frame
    push_exp(8'h03, 8'd1, 8'h44, 8'h00);
    send_byte(8'h55, 3);
    send_byte(8'h13, 3);
    send_byte(8'hAA, 3);
    send_byte(8'h03, 3);
    send_byte(8'h01, 3);
    send_byte(8'h44, 3);
    send_byte(8'h46, 3);
    check_cmd("noise", 1'b1);

    // Length too large
    send_byte(8'hAA, 3);
    send_byte(8'h01, 3);
    send_byte(8'h11, 3);
    check("len_pulse", 32'(err_len), 32'd1);
    @(negedge clk);
    check("len_pulse_end", 32'(err_len), 32'd0);
    push_exp(8'h02, 8'd0, 8'h00, 8'h00);
    send_byte(8'hAA, 1);
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    check_cmd("after_len", 1'b1);

    // Timeout mid-payload
    send_byte(8'hAA, 3);
    send_byte(8'h01, 3);
    send_byte(8'h02, 3);
    send_byte(8'h11, 3);
    repeat (1999) @(negedge clk);
    check("tmo_not_yet", 32'(err_timeout), 32'd0);
    @(negedge clk);
    check("tmo_pulse", 32'(err_timeout), 32'd1);
    @(negedge clk);
    check("tmo_pulse_end", 32'(err_timeout), 32'd0);
    push_exp(8'h09, 8'd0, 8'h00, 8'h00);
    send_byte(8'hAA, 3);
    send_byte(8'h09, 3);
    send_byte(8'h00, 3);
    send_byte(8'h09, 3);
    check_cmd("after_tmo", 1'b1);

    // Byte on exactly the expiry cycle keeps the frame alive
    push_exp(8'h01, 8'd2, 8'h11, 8'h22);
    send_byte(8'hAA, 3);
    send_byte(8'h01, 3);
    send_byte(8'h02, 3);
    send_byte(8'h11, 3);
    send_byte(8'h22, 1999);
    check("tmo_edge_none", 32'(err_timeout), 32'd0);
    send_byte(8'h30, 5);
    check_cmd("tmo_edge", 1'b1);

    // Overrun while holding, then overrun on the handshake cycle
    push_exp(8'h04, 8'd1, 8'h77, 8'h00);
    send_byte(8'hAA, 3);
    send_byte(8'h04, 3);
    send_byte(8'h01, 3);
    send_byte(8'h77, 3);
    send_byte(8'h72, 3);
    check_cmd("ovr_hold", 1'b0);
    send_byte(8'hAA, 5);
    check("ovr_pulse", 32'(err_overrun), 32'd1);
    check("ovr_op",    32'(cmd_op),      32'h04);
    check("ovr_len",   32'(cmd_len),     32'd1);
    check("ovr_valid", 32'(cmd_valid),   32'd1);
    @(negedge clk);
    check("ovr_pulse_end", 32'(err_overrun), 32'd0);
    cmd_ready = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = 8'hAA;
    @(negedge clk);
    cmd_ready = 1'b0;
    rx_valid  = 1'b0;
    check("ovr_hs_pulse", 32'(err_overrun), 32'd1);
    check("ovr_hs_valid", 32'(cmd_valid),   32'd0);
    send_byte(8'h04, 3);
    send_byte(8'h00, 3);
    send_byte(8'h04, 3);
    check("ovr_hs_no_sof", 32'(cmd_valid), 32'd0);

    // Reset mid-payload
    send_byte(8'hAA, 3);
    send_byte(8'h01, 3);
    send_byte(8'h03, 3);
    send_byte(8'h11, 3);
    check("rstpay_op_before", 32'(cmd_op), 32'h01);
    #2;
    rst = 1'b0;
    #1;
    check("rstpay_op",  32'(cmd_op),  32'h00);
    check("rstpay_len", 32'(cmd_len), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h22, 3);
    send_byte(8'h33, 3);
    send_byte(8'h02, 3);
    check("rstpay_no_frame", 32'(cmd_valid), 32'd0);

    // Reset while holding
    push_exp(8'h06, 8'd0, 8'h00, 8'h00);
    send_byte(8'hAA, 3);
    send_byte(8'h06, 3);
    send_byte(8'h00, 3);
    send_byte(8'h06, 3);
    check_cmd("rsthold", 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("rsthold_valid", 32'(cmd_valid), 32'd0);
    check("rsthold_op",    32'(cmd_op),    32'h00);
    @(negedge clk);
    rst = 1'b1;

    // Final sanity frame
    push_exp(8'h08, 8'd1, 8'h99, 8'h00);
    send_byte(8'hAA, 3);
    send_byte(8'h08, 3);
    send_byte(8'h01, 3);
    send_byte(8'h99, 3);
    send_byte(8'h90, 3);
    check_cmd("final", 1'b1);

    repeat (3) @(negedge clk);
    check("tot_err_chk",     32'(n_chk),   32'd1);
    check("tot_err_len",     32'(n_len),   32'd1);
    check("tot_err_timeout", 32'(n_tmo),   32'd1);
    check("tot_err_overrun", 32'(n_ovr),   32'd2);
    check("err_one_hot",     32'(n_multi), 32'd0);
    check("sb_drained",      32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
